// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the operand registers and the sequential divider.
// The master drives the request and operands. The slave returns status and results.
interface seq_divider_if #(
  parameter int N = 8
);
  logic         start_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_by_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider that produces one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to divide two's complement operands with truncation toward zero.
module seq_divider #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  v_q, v_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    trial;
  logic          fits;
  logic [N-1:0]  remStep;
  logic [N-1:0]  quoStep;
  logic [N-1:0]  opA, opB;
  logic [N-1:0]  quoRes, remRes;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic          dvdNeg_q, dvdNeg_d;
  logic          dvsNeg_q, dvsNeg_d;
`endif

  // The partial remainder is always below the divisor, so N bits hold it.
  // The trial value keeps its extra bit for the compare.
  always_comb begin
    trial   = {r_q, d_q[N-1]};
    fits    = (trial >= {1'b0, v_q});
    remStep = fits ? (trial[N-1:0] - v_q) : trial[N-1:0];
    quoStep = {q_q[N-2:0], fits};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  // The quotient is negated only for a real division. A zero divisor keeps all ones.
  always_comb begin
    opA    = bus.dividend_i[N-1] ? (~bus.dividend_i + N'(1)) : bus.dividend_i;
    opB    = bus.divisor_i[N-1]  ? (~bus.divisor_i  + N'(1)) : bus.divisor_i;
    quoRes = ((dvdNeg_q ^ dvsNeg_q) && !dbz_q) ? (~quoStep + N'(1)) : quoStep;
    remRes = dvdNeg_q ? (~remStep + N'(1)) : remStep;
  end
`else
  always_comb begin
    opA    = bus.dividend_i;
    opB    = bus.divisor_i;
    quoRes = quoStep;
    remRes = remStep;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    q_d     = q_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvdNeg_d = dvdNeg_q;
    dvsNeg_d = dvsNeg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          cnt_d   = CW'(N - 1);
          d_d     = opA;
          v_d     = opB;
          r_d     = '0;
          q_d     = '0;
          dbz_d   = (bus.divisor_i == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
          dvdNeg_d = bus.dividend_i[N-1];
          dvsNeg_d = bus.divisor_i[N-1];
`endif
        end
      end
      RUN: begin
        d_d   = d_q << 1;
        r_d   = remStep;
        q_d   = quoStep;
        cnt_d = cnt_q - CW'(1);
        // Results are loaded only on the final step, so they stay stable while the divider runs.
        if (cnt_q == '0) begin
          state_d = FIN;
          cnt_d   = '0;
          quo_d   = quoRes;
          rem_d   = remRes;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      q_q     <= q_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvdNeg_q <= 1'b0;
      dvsNeg_q <= 1'b0;
    end else begin
      dvdNeg_q <= dvdNeg_d;
      dvsNeg_q <= dvsNeg_d;
    end
  end
`endif

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = (state_q == FIN);
  assign bus.quotient_o    = quo_q;
  assign bus.remainder_o   = rem_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule
